// File: rtl/serial_pkg.sv
// Shared definitions for the serial link transmitter and receiver.
// State encoding and line levels are common to both ends.
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_LVL = 1'b0;

endpackage

// File: rtl/serial_tx_if.sv
// Load handshake and serial line signals of the framed transmitter.
interface serial_tx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] DIN;
    logic              LOAD;
    logic              READY;
    logic              TXD;
    logic              BUSY;
    logic              DONE;

    modport master (output DIN, LOAD, input READY, TXD, BUSY, DONE);
    modport slave  (input DIN, LOAD, output READY, TXD, BUSY, DONE);
endinterface

// File: rtl/serial_tx_bit_timer.sv
// Per-bit cycle counter: TICK marks the last clock of a serial bit.
module bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic CLR,
    output logic TICK
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CW-1:0] count;

    // With CLKS_PER_BIT=1 the count never leaves zero, so TICK is constant high.
    assign TICK = (count == CW'(CLKS_PER_BIT - 1));

    always_ff @(posedge CLK) begin
        if (RST || CLR || TICK)
            count <= '0;
        else
            count <= count + CW'(1);
    end
endmodule

// File: rtl/serial_tx.sv
// Framed LSB-first serial transmitter: start bit, DATA_W data bits, stop bit.
// Define SERIAL_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module serial_tx
    import serial_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       CLK,
    input  logic       RST,
    serial_tx_if.slave bus
);
    localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    state_t            state, state_nx;
    logic [IW-1:0]     idx, idx_nx;
    logic [DATA_W-1:0] shreg, shreg_nx;
    logic              txd, txd_nx;
    logic              done;
    logic              tick;

    bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .CLK  (CLK),
        .RST  (RST),
        .CLR  (state == IDLE),
        .TICK (tick)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            idx   <= '0;
            shreg <= '0;
            txd   <= LINE_IDLE;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
            shreg <= shreg_nx;
            txd   <= txd_nx;
        end
    end

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        shreg_nx = shreg;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.LOAD) begin
                    shreg_nx = bus.DIN;
                    idx_nx   = '0;
                    state_nx = START;
                end
            end
            START: if (tick) state_nx = DATA;
            DATA: begin
                if (tick) begin
                    if (idx == IW'(DATA_W - 1)) begin
                        idx_nx = '0;
`ifdef SERIAL_TX_PARITY_EN
                        state_nx = PARITY;
`else
                        state_nx = STOP;
`endif
                    end else begin
                        idx_nx = idx + IW'(1);
                    end
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            PARITY: if (tick) state_nx = STOP;
`endif
            STOP: begin
                if (tick) begin
                    done     = !RST;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase

        // TXD is registered, so it is computed from the state being entered.
        case (state_nx)
            START:   txd_nx = START_LVL;
            DATA:    txd_nx = shreg_nx[idx_nx];
`ifdef SERIAL_TX_PARITY_EN
            PARITY:  txd_nx = ^shreg_nx;
`endif
            default: txd_nx = LINE_IDLE;
        endcase
    end

    assign bus.TXD   = txd;
    assign bus.READY = (state == IDLE);
    assign bus.BUSY  = (state != IDLE);
    assign bus.DONE  = done;
endmodule

// File: tb/tb_serial_tx.sv
// Self-checking bench for serial_tx: two instances (4 and 1 clocks per bit)
// compared cycle by cycle against an expected bit-list frame model.
module tb_serial_tx;
`ifdef SERIAL_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_r  [2];
    logic       load_r [2];
    logic [7:0] din_r  [2];
    int         dcnt   [2];
    int         n_checks = 0;
    int         n_fail   = 0;

    serial_tx_if #(.DATA_W(8)) bus4 ();
    serial_tx_if #(.DATA_W(8)) bus1 ();

    assign bus4.DIN  = din_r[0];
    assign bus4.LOAD = load_r[0];
    assign bus1.DIN  = din_r[1];
    assign bus1.LOAD = load_r[1];

    serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) u_dut4 (
        .CLK (clk),
        .RST (rst_r[0]),
        .bus (bus4.slave)
    );

    serial_tx #(.DATA_W(8), .CLKS_PER_BIT(1)) u_dut1 (
        .CLK (clk),
        .RST (rst_r[1]),
        .bus (bus1.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus4.DONE) dcnt[0] <= dcnt[0] + 1;
        if (bus1.DONE) dcnt[1] <= dcnt[1] + 1;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // {TXD, READY, BUSY, DONE}
    function automatic logic [3:0] outs(input int sel);
        if (sel == 1) return {bus1.TXD, bus1.READY, bus1.BUSY, bus1.DONE};
        return {bus4.TXD, bus4.READY, bus4.BUSY, bus4.DONE};
    endfunction

    function automatic int frame_len(input int sel);
        return (8 + 2 + PB) * ((sel == 1) ? 1 : 4);
    endfunction

    task automatic check_idle(input int sel, input string tag);
        logic [3:0] o;
        o = outs(sel);
        check({tag, "_txd"},   o[3], 1);
        check({tag, "_ready"}, o[2], 1);
        check({tag, "_busy"},  o[1], 0);
        check({tag, "_done"},  o[0], 0);
    endtask

    // Entered at the negedge of cycle 1 after acceptance; leaves at cycle N+1.
    task automatic expect_frame(input int sel, input logic [7:0] word,
                                input int junk_at, input int rst_at);
        bit         q[$];
        int         cpb, n, d0;
        logic [3:0] o;
        cpb = (sel == 1) ? 1 : 4;
        q.push_back(1'b0);
        for (int i = 0; i < 8; i++) q.push_back(word[i]);
        if (PB == 1) q.push_back(^word);
        q.push_back(1'b1);
        n  = q.size() * cpb;
        d0 = dcnt[sel];
        for (int k = 1; k <= n; k++) begin
            o = outs(sel);
            if (k == rst_at) begin
                rst_r[sel] = 1'b1;
                @(negedge clk);
                o = outs(sel);
                check("rst_txd",   o[3], 1);
                check("rst_ready", o[2], 1);
                check("rst_busy",  o[1], 0);
                check("rst_done",  o[0], 0);
                check("rst_no_done_pulse", dcnt[sel] - d0, 0);
                rst_r[sel] = 1'b0;
                return;
            end
            check("frame_txd",   o[3], q[(k - 1) / cpb]);
            check("frame_ready", o[2], 0);
            check("frame_busy",  o[1], 1);
            check("frame_done",  o[0], (k == n) ? 1 : 0);
            if (k == junk_at) begin
                load_r[sel] = 1'b1;
                din_r[sel]  = 8'hFF;
            end
            if (junk_at > 0 && k == junk_at + 1) load_r[sel] = 1'b0;
            @(negedge clk);
        end
        check("done_pulse_count", dcnt[sel] - d0, 1);
    endtask

    task automatic send(input int sel, input logic [7:0] word,
                        input int junk_at, input int rst_at);
        check("ready_before_load", outs(sel) >> 2 & 4'b1, 1);
        din_r[sel]  = word;
        load_r[sel] = 1'b1;
        @(negedge clk);
        load_r[sel] = 1'b0;
        din_r[sel]  = 8'($urandom);
        expect_frame(sel, word, junk_at, rst_at);
        check_idle(sel, "post_frame");
    endtask

    initial begin
        logic [7:0] w;
        int         sel, junk, gap;
        for (int s = 0; s < 2; s++) begin
            rst_r[s]  = 1'b1;
            load_r[s] = 1'b0;
            din_r[s]  = '0;
            dcnt[s]   = 0;
        end
        repeat (3) @(negedge clk);
        check_idle(0, "reset4");
        check_idle(1, "reset1");
        rst_r[0] = 1'b0;
        rst_r[1] = 1'b0;
        @(negedge clk);

        send(0, 8'hA5, 0, 0);
        send(0, 8'hA5, 10, 0);
        @(negedge clk);
        check_idle(0, "no_second_frame");
        send(0, 8'h5A, 0, 15);
        send(0, 8'h3C, 0, 0);

        // Back-to-back with LOAD held high on the one-clock-per-bit instance.
        din_r[1]  = 8'h01;
        load_r[1] = 1'b1;
        @(negedge clk);
        din_r[1] = 8'h80;
        expect_frame(1, 8'h01, 0, 0);
        check_idle(1, "b2b_gap");
        @(negedge clk);
        load_r[1] = 1'b0;
        expect_frame(1, 8'h80, 0, 0);
        check_idle(1, "b2b_end");

        for (int it = 0; it < 16; it++) begin
            sel  = int'($urandom_range(0, 1));
            w    = 8'($urandom);
            junk = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, frame_len(sel) - 2)) : 0;
            send(sel, w, junk, 0);
            gap = int'($urandom_range(0, 2));
            repeat (gap) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
